vga_vram_arbiter: RTL and testbench
===================================

// Module: vga_vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM between the VGA pixel fetch and a CPU requester.
//  Sits between the VGA timing generator (h_count/v_count/bright/25 MHz phase) and the VRAM.
//  Display reads own every pixel-phase slot in the active region; the CPU gets all other cycles.
//  Returns fetched pixels to the colour output stage and acks CPU reads/writes.
// PARAMETERS
//  H_RES         640  visible pixels per line
//  V_RES         480  visible lines per frame
//  COUNTER_BITS  16   width of h_count/v_count
//  ADDR_BITS     19   VRAM word address width (H_RES*V_RES must fit)
//  DATA_BITS     8    VRAM word / pixel width
// PORTS
//  clk_50MHz    in   1             system clock, all logic on posedge
//  clear        in   1             synchronous active-low reset
//  pix_phase    in   1             timing generator's clk_25MHz level; 1 = display slot
//  bright       in   1             active-video flag from timing generator
//  h_count      in   COUNTER_BITS  current pixel column
//  v_count      in   COUNTER_BITS  current line
//  cpu_req      in   1             CPU request; held with addr/we/wdata stable until cpu_ack
//  cpu_we       in   1             1 = write, 0 = read
//  cpu_addr     in   ADDR_BITS     CPU word address
//  cpu_wdata    in   DATA_BITS     CPU write data
//  cpu_ack      out  1             one-cycle completion pulse
//  cpu_rdata    out  DATA_BITS     read data, valid with cpu_ack
//  mem_addr     out  ADDR_BITS     VRAM address (registered)
//  mem_we       out  1             VRAM write strobe (registered, one-cycle pulses)
//  mem_wdata    out  DATA_BITS     VRAM write data (registered)
//  mem_rdata    in   DATA_BITS     VRAM read data, valid one edge after RAM samples mem_addr
//  pixel        out  DATA_BITS     fetched pixel value
//  pixel_valid  out  1             one-cycle pulse when pixel updated from VRAM
// BEHAVIOUR
//  Reset (clear=0 at an edge): all outputs 0, CPU FSM -> C_IDLE, return-tag pipe cleared, in-flight op dropped, no ack.
//  Slot rule, evaluated each edge:
//   - pix_phase=1 & bright=1 & h_count<H_RES & v_count<V_RES: display read; mem_addr<=v_count*H_RES+h_count
//     (truncated to ADDR_BITS), mem_we<=0. Display always wins; a simultaneous CPU issue waits.
//   - else if CPU FSM in C_IDLE & cpu_req: CPU issue (see FSM).
//   - else mem_we<=0, mem_addr holds.
//  Read latency: issue = edge 0; RAM samples at edge 1; arbiter captures mem_rdata at edge 2.
//  2-bit owner tag pipe (DISP/CPU/NONE) routes each capture; only one tag per issue edge.
//  Display return at edge 2: pixel<=mem_rdata, pixel_valid<=1. Otherwise pixel_valid<=0; if bright=0
//   and no display return that edge, pixel<=0.
//  CPU FSM:
//   C_IDLE:  on CPU issue: addr in range -> mem_addr<=cpu_addr, mem_we<=cpu_we, mem_wdata<=cpu_wdata;
//            write -> C_WACK; read -> C_RW1. cpu_addr>=H_RES*V_RES -> no RAM access, cpu_rdata<=0, -> C_WACK.
//   C_WACK:  cpu_ack=1 this cycle (registered at edge 1) -> C_IDLE.
//   C_RW1:   RAM sampling -> C_RW2.
//   C_RW2:   edge 2 captures cpu_rdata<=mem_rdata, cpu_ack<=1 -> C_IDLE.
//  Only one CPU op outstanding; new request accepted no earlier than the edge after cpu_ack falls.
//  CPU issue blocked at most 1 cycle during active video (pix_phase toggles every cycle).
//  cpu_ack dropped if clear asserted between issue and ack; cpu_rdata holds last value otherwise.
//  mem_we never high for a display slot; never two consecutive write pulses for one request.
// TESTING
//  1 clear=0 for 3 edges with cpu_req=1,bright=1 -> cpu_ack,mem_we,pixel,pixel_valid all 0 throughout.
//  2 bright=1,pix_phase=1,h=5,v=2 -> mem_addr=1285,mem_we=0; RAM model returns 8'hA5 -> pixel=8'hA5,pixel_valid=1 at edge 2.
//  3 bright=0, write addr=100,wdata=8'h3C -> mem_we=1 for exactly one cycle with mem_addr=100; cpu_ack one cycle later, single pulse.
//  4 bright=1,pix_phase=1 with CPU read addr=7 same edge -> display issued first, CPU read issued next edge; cpu_ack+cpu_rdata 2 edges after; display fetch every other cycle unbroken.
//  5 CPU write addr=307200 (H_RES*V_RES) -> cpu_ack at edge 1, mem_we stays 0, cpu_rdata=0.
//  6 clear=0 one edge after CPU read issue -> no cpu_ack ever; after release a new read addr=7 completes normally.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: time-shares one single-port synchronous VRAM between the
// VGA pixel fetch and a CPU requester. Display reads own every pixel-phase
// slot inside the visible area; the CPU is served in all remaining cycles.
module vga_vram_arbiter #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int COUNTER_BITS = 16,
  parameter int ADDR_BITS    = 19,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  input  logic                    pix_phase,
  input  logic                    bright,
  input  logic [COUNTER_BITS-1:0] h_count,
  input  logic [COUNTER_BITS-1:0] v_count,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_BITS-1:0]    cpu_addr,
  input  logic [DATA_BITS-1:0]    cpu_wdata,
  output logic                    cpu_ack,
  output logic [DATA_BITS-1:0]    cpu_rdata,
  output logic [ADDR_BITS-1:0]    mem_addr,
  output logic                    mem_we,
  output logic [DATA_BITS-1:0]    mem_wdata,
  input  logic [DATA_BITS-1:0]    mem_rdata,
  output logic [DATA_BITS-1:0]    pixel,
  output logic                    pixel_valid
);

  localparam logic [COUNTER_BITS-1:0] H_LIM     = COUNTER_BITS'(H_RES);
  localparam logic [COUNTER_BITS-1:0] V_LIM     = COUNTER_BITS'(V_RES);
  localparam logic [ADDR_BITS:0]      PIX_TOTAL = (ADDR_BITS+1)'(H_RES * V_RES);

  typedef enum logic [1:0] {C_IDLE, C_WACK, C_RW1, C_RW2} cpu_state_t;
  typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU} owner_tag_t;

  cpu_state_t state_q, state_d;
  owner_tag_t tag_q, tag_qq;

  logic                 disp_slot;
  logic                 cpu_issue;
  logic                 cpu_in_range;
  logic [ADDR_BITS-1:0] disp_addr;

  assign disp_slot    = pix_phase && bright && (h_count < H_LIM) && (v_count < V_LIM);
  // The ack register term keeps a request that is still held during its own
  // ack cycle from being reissued; the next op starts after ack falls.
  assign cpu_issue    = !disp_slot && (state_q == C_IDLE) && cpu_req && !cpu_ack;
  assign cpu_in_range = {1'b0, cpu_addr} < PIX_TOTAL;
  // Modular arithmetic at ADDR_BITS gives the truncated linear address directly.
  assign disp_addr    = ADDR_BITS'(v_count) * ADDR_BITS'(H_LIM) + ADDR_BITS'(h_count);

  // CPU FSM state register.
  always_ff @(posedge clk_50MHz) begin
    if (!clear) state_q <= C_IDLE;
    else        state_q <= state_d;
  end

  // CPU FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE:  if (cpu_issue) state_d = (cpu_we || !cpu_in_range) ? C_WACK : C_RW1;
      C_WACK:  state_d = C_IDLE;
      C_RW1:   state_d = C_RW2;
      C_RW2:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Memory port, owner-tag pipe and return routing to pixel / CPU outputs.
  always_ff @(posedge clk_50MHz) begin
    if (!clear) begin
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      tag_q       <= T_NONE;
      tag_qq      <= T_NONE;
    end else begin
      mem_we      <= 1'b0;
      cpu_ack     <= 1'b0;
      pixel_valid <= 1'b0;
      tag_q       <= T_NONE;
      tag_qq      <= tag_q;

      if (disp_slot) begin
        mem_addr <= disp_addr;
        tag_q    <= T_DISP;
      end else if (cpu_issue) begin
        if (cpu_in_range) begin
          mem_addr  <= cpu_addr;
          mem_we    <= cpu_we;
          mem_wdata <= cpu_wdata;
          if (!cpu_we) tag_q <= T_CPU;
        end else begin
          cpu_rdata <= '0;
        end
      end

      if (state_q == C_WACK) cpu_ack <= 1'b1;

      if (tag_qq == T_CPU) begin
        cpu_rdata <= mem_rdata;
        cpu_ack   <= 1'b1;
      end

      if (tag_qq == T_DISP) begin
        pixel       <= mem_rdata;
        pixel_valid <= 1'b1;
      end else if (!bright) begin
        pixel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed checks of slot arbitration, read latency,
// CPU handshake, out-of-range handling and reset abort. The VRAM model
// returns addr[7:0]^8'hA0 for never-written words, else the written byte.
module tb_vga_vram_arbiter;

  logic        clk_50MHz = 1'b0;
  logic        clear;
  logic        pix_phase;
  logic        bright;
  logic [15:0] h_count;
  logic [15:0] v_count;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pixel;
  logic        pixel_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] wr_mem [int unsigned];

  vga_vram_arbiter #(
    .H_RES(640), .V_RES(480), .COUNTER_BITS(16), .ADDR_BITS(19), .DATA_BITS(8)
  ) dut (
    .clk_50MHz(clk_50MHz), .clear(clear), .pix_phase(pix_phase), .bright(bright),
    .h_count(h_count), .v_count(v_count), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Single-port synchronous VRAM model, read-before-write.
  always @(posedge clk_50MHz) begin
    logic [7:0] rd;
    logic [7:0] lo;
    lo = mem_addr[7:0];
    rd = wr_mem.exists(int'(mem_addr)) ? wr_mem[int'(mem_addr)] : (lo ^ 8'hA0);
    if (mem_we) wr_mem[int'(mem_addr)] = mem_wdata;
    mem_rdata <= rd;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [18:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    clear = 1'b0; pix_phase = 1'b1; bright = 1'b1; h_count = 16'd0; v_count = 16'd0;
    cpu_set(1'b1, 1'b1, 19'd3, 8'h77);

    // 1: reset held with activity on every input
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ack", 32'(cpu_ack), 32'd0);
      check_eq("rst_we", 32'(mem_we), 32'd0);
      check_eq("rst_pixel", 32'(pixel), 32'd0);
      check_eq("rst_pvalid", 32'(pixel_valid), 32'd0);
    end
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    bright = 1'b0; pix_phase = 1'b0; clear = 1'b1;
    tick(); tick();

    // 2: display fetch of (h=5, v=2) -> word 1285, pattern 0xA5
    bright = 1'b1; pix_phase = 1'b1; h_count = 16'd5; v_count = 16'd2;
    tick();
    check_eq("disp_addr", 32'(mem_addr), 32'd1285);
    check_eq("disp_we", 32'(mem_we), 32'd0);
    pix_phase = 1'b0;
    tick();
    check_eq("disp_pv_e1", 32'(pixel_valid), 32'd0);
    tick();
    check_eq("disp_pixel", 32'(pixel), 32'hA5);
    check_eq("disp_pv_e2", 32'(pixel_valid), 32'd1);
    tick();
    check_eq("disp_pv_e3", 32'(pixel_valid), 32'd0);
    check_eq("disp_hold", 32'(pixel), 32'hA5);
    bright = 1'b0;
    tick();
    check_eq("blank_pixel", 32'(pixel), 32'd0);

    // 3: CPU write addr 100 during blanking
    cpu_set(1'b1, 1'b1, 19'd100, 8'h3C);
    tick();
    check_eq("wr_we", 32'(mem_we), 32'd1);
    check_eq("wr_addr", 32'(mem_addr), 32'd100);
    check_eq("wr_data", 32'(mem_wdata), 32'h3C);
    check_eq("wr_ack_e0", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("wr_we_e1", 32'(mem_we), 32'd0);
    check_eq("wr_ack_e1", 32'(cpu_ack), 32'd1);
    tick();
    check_eq("wr_we_e2", 32'(mem_we), 32'd0);
    check_eq("wr_ack_e2", 32'(cpu_ack), 32'd0);
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    tick();
    check_eq("wr_we_e3", 32'(mem_we), 32'd0);

    // 4: display and CPU read collide; display first, CPU next cycle
    bright = 1'b1; pix_phase = 1'b1; h_count = 16'd10; v_count = 16'd0;
    cpu_set(1'b1, 1'b0, 19'd7, 8'h00);
    tick();                                   // e0: display 10
    check_eq("col_addr_e0", 32'(mem_addr), 32'd10);
    check_eq("col_we_e0", 32'(mem_we), 32'd0);
    pix_phase = 1'b0;
    tick();                                   // e1: CPU read 7
    check_eq("col_addr_e1", 32'(mem_addr), 32'd7);
    check_eq("col_we_e1", 32'(mem_we), 32'd0);
    check_eq("col_ack_e1", 32'(cpu_ack), 32'd0);
    pix_phase = 1'b1; h_count = 16'd11;
    tick();                                   // e2: display 11, pixel from 10
    check_eq("col_addr_e2", 32'(mem_addr), 32'd11);
    check_eq("col_pix_e2", 32'(pixel), 32'hAA);
    check_eq("col_pv_e2", 32'(pixel_valid), 32'd1);
    check_eq("col_ack_e2", 32'(cpu_ack), 32'd0);
    pix_phase = 1'b0;
    tick();                                   // e3: CPU read returns
    check_eq("col_ack_e3", 32'(cpu_ack), 32'd1);
    check_eq("col_rdata", 32'(cpu_rdata), 32'hA7);
    check_eq("col_pv_e3", 32'(pixel_valid), 32'd0);
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    pix_phase = 1'b1; h_count = 16'd12;
    tick();                                   // e4: display 12, pixel from 11
    check_eq("col_addr_e4", 32'(mem_addr), 32'd12);
    check_eq("col_pix_e4", 32'(pixel), 32'hAB);
    check_eq("col_ack_e4", 32'(cpu_ack), 32'd0);
    pix_phase = 1'b0;
    tick();
    pix_phase = 1'b1; h_count = 16'd13;
    tick();                                   // e6: pixel from 12
    check_eq("col_pix_e6", 32'(pixel), 32'hAC);
    check_eq("col_pv_e6", 32'(pixel_valid), 32'd1);
    bright = 1'b0; pix_phase = 1'b0;
    tick(); tick(); tick();

    // 5: out-of-range write at H_RES*V_RES
    cpu_set(1'b1, 1'b1, 19'd307200, 8'hFF);
    tick();
    check_eq("oor_we_e0", 32'(mem_we), 32'd0);
    check_eq("oor_ack_e0", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("oor_ack_e1", 32'(cpu_ack), 32'd1);
    check_eq("oor_we_e1", 32'(mem_we), 32'd0);
    check_eq("oor_rdata", 32'(cpu_rdata), 32'd0);
    tick();
    check_eq("oor_ack_e2", 32'(cpu_ack), 32'd0);
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    tick();

    // 6: reset aborts an in-flight read; a fresh read then completes
    cpu_set(1'b1, 1'b0, 19'd7, 8'h00);
    tick();
    clear = 1'b0;
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    tick();
    check_eq("abort_ack_rst", 32'(cpu_ack), 32'd0);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("abort_ack", 32'(cpu_ack), 32'd0);
    end
    cpu_set(1'b1, 1'b0, 19'd7, 8'h00);
    tick();
    check_eq("rd7_ack_e0", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("rd7_ack_e1", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("rd7_ack_e2", 32'(cpu_ack), 32'd1);
    check_eq("rd7_rdata", 32'(cpu_rdata), 32'hA7);
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    tick(); tick();

    // Read back the earlier write at address 100.
    cpu_set(1'b1, 1'b0, 19'd100, 8'h00);
    tick(); tick(); tick();
    check_eq("rd100_ack", 32'(cpu_ack), 32'd1);
    check_eq("rd100_rdata", 32'(cpu_rdata), 32'h3C);
    cpu_set(1'b0, 1'b0, 19'd0, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
